// File: rtl/jt51_kon_req.sv
// Key-on request queue: captures CPU writes to the key-on register and
// replays each one as a frame-aligned, one-rotation keyon window.
module jt51_kon_req #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] KON_ADDR = 8'h08,
  parameter int         FRAME    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic [1:0] cur_op,
  input  logic [2:0] cur_ch,
  output logic [3:0] keyon_op,
  output logic [2:0] keyon_ch,
  output logic       up_keyon,
  output logic       busy,
  output logic       full,
  output logic [7:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(FRAME);

  typedef enum logic [1:0] {IDLE, ALIGN, APPLY} state_t;

  state_t        state, state_nxt;
  logic [6:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [SW-1:0] slot;
  logic          empty, frame_start, slot_last, kon_wr;
  logic          pop, push, drop, up_clr;
  logic          unused_din;

  // Bit 7 of the key-on data carries no meaning here.
  assign unused_din  = cpu_din[7];

  // Extra pointer bit separates the full case from the empty case.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign busy        = !empty || (state != IDLE);
  assign frame_start = (cur_op == 2'd0) && (cur_ch == 3'd0);
  assign slot_last   = (slot == SW'(FRAME - 1));
  assign kon_wr      = cpu_we && (cpu_addr == KON_ADDR);
  // A pop on the same edge frees a slot, so a write into a full queue survives.
  assign push        = kon_wr && (!full || pop);
  assign drop        = kon_wr && full && !pop;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = ALIGN;
      ALIGN:   if (frame_start && !empty) state_nxt = APPLY;
      APPLY:   if (slot_last && empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: when to pop the queue and when the window closes.
  always_comb begin
    pop    = 1'b0;
    up_clr = 1'b0;
    case (state)
      ALIGN: pop = frame_start && !empty;
      APPLY: begin
        if (slot_last) begin
          if (!empty) pop    = 1'b1;
          else        up_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Queue storage; stale contents are harmless once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cpu_din[6:3], cpu_din[2:0]};
  end

  // Queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Slot counter restarts on every pop so back-to-back windows stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              slot <= '0;
    else if (pop)            slot <= '0;
    else if (state == APPLY) slot <= slot + 1'b1;
  end

  // Request outputs load on pop and hold their value after the window closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyon_op <= '0;
      keyon_ch <= '0;
      up_keyon <= 1'b0;
    end else begin
      if (pop) begin
        keyon_op <= mem[rd_ptr[AW-1:0]][6:3];
        keyon_ch <= mem[rd_ptr[AW-1:0]][2:0];
        up_keyon <= 1'b1;
      end else if (up_clr) begin
        up_keyon <= 1'b0;
      end
    end
  end

  // Saturating count of writes lost to a full queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: doc/jt51_kon_req.md
Name: jt51_kon_req

Overview:
- Upstream feeder of the key-on shift stage; sits between the CPU register write path and the key-on stage.
- Captures CPU writes to the key-on register (0x08) into a small FIFO.
- Replays each request as a frame-aligned `keyon_ch`/`keyon_op`/`up_keyon` window lasting one full 32-slot rotation, so all four operators of the target channel are sampled.
- Back-to-back CPU writes are never silently merged; they are applied in order or counted as dropped.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- KON_ADDR, 8'h08, register address decoded as key-on.
- FRAME, 32, slots per rotation (`up_keyon` window length).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_we  in  1  one-cycle register write strobe.
- cpu_addr  in  8  register address, qualified by cpu_we.
- cpu_din  in  8  register data; [2:0] channel, [6:3] operator mask (bit3 M1, bit4 C1, bit5 M2, bit6 C2), bit7 ignored.
- cur_op  in  2  current operator slot from the timing counter.
- cur_ch  in  3  current channel slot from the timing counter.
- keyon_op  out  4  operator mask of the request being applied; bit order M1,C1,M2,C2 = [0..3].
- keyon_ch  out  3  channel of the request being applied.
- up_keyon  out  1  high for exactly FRAME cycles per request.
- busy  out  1  FIFO non-empty or window active.
- full  out  1  FIFO holds DEPTH entries.
- drop_cnt  out  8  saturating count of writes lost to a full FIFO.

Behaviour:
Reset:
- Async on rst_n low: FIFO empty, state IDLE.
- `keyon_op`=0, `keyon_ch`=0, `up_keyon`=0, `busy`=0, `full`=0, `drop_cnt`=0.
- Reset asserted mid-window kills `up_keyon` immediately; the pending entry is discarded.

Capture:
- Push when `cpu_we` && `cpu_addr`==KON_ADDR && !`full`.
- The entry stored is {`cpu_din`[6:3], `cpu_din`[2:0]}.
- Other addresses are ignored.
- Push when `full`: the write is discarded and `drop_cnt` is incremented, saturating at 255.
- `full` and `busy` are registered and reflect the FIFO state after the edge.

Frame start:
- Frame start is the cycle where `cur_op`==0 && `cur_ch`==0.

FSM (3 states):
- IDLE: if FIFO non-empty, go to ALIGN.
- ALIGN: on a frame-start cycle, pop the head entry, load `keyon_op`/`keyon_ch`, set `up_keyon`=1, clear slot counter, go to APPLY. All three outputs change on the same edge.
- APPLY: the slot counter counts 0..FRAME-1. On the edge where the count reaches FRAME-1:
  - If the FIFO is non-empty at that edge, pop the next entry and load it directly; `up_keyon` stays high with no gap. The timing counter is back at frame start, so this remains aligned.
  - Otherwise clear `up_keyon`, return to IDLE, and hold `keyon_op`/`keyon_ch` at their last value.

Latency and timing:
- Write accepted at edge t; the earliest `up_keyon` rise is at the first frame-start edge after t+1.
- Worst case is FRAME+1 cycles.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Push into a full FIFO that pops on the same edge is accepted, because `full` is evaluated after the pop.
- Read/write pointers wrap modulo DEPTH, using an extra bit to distinguish full from empty.

Other rules:
- Identical back-to-back requests are still applied twice (no coalescing).
- The timing counter is free-running. If frame start never occurs, the block stays in ALIGN with `busy`=1; this is not an error.

Test Plan:
1. Reset, write 0x08←0x7A while the timing counter is at slot (op1,ch3) -> at the next (op0,ch0) edge: `keyon_ch`=2, `keyon_op`=4'hF, `up_keyon`=1 for exactly 32 cycles, then 0; `busy` falls on the same edge.
2. Five consecutive writes 0x08←0x08,0x11,0x1A,0x23,0x2C with DEPTH=4 and the FSM idle -> `full`=1 after the 4th, `drop_cnt`=1. Four contiguous 32-cycle windows follow with (ch,op)=(0,1),(1,2),(2,3),(3,4); the 5th write (0x2C) is dropped; `up_keyon` stays high for 128 cycles with no gap.
3. Writes to 0x20 and 0x09 with data 0xFF -> no push, `busy` stays 0, `drop_cnt` stays 0.
4. Window active, FIFO full, write 0x08←0x45 on the edge the window ends -> pop and push both occur; `drop_cnt` unchanged; entry (ch5,op8) is applied 3 windows later.
5. Deassert rst_n 10 cycles into a window -> `up_keyon`, `busy`, `full` and `drop_cnt` go to 0 asynchronously. After release with no writes, `up_keyon` stays 0 for ≥64 cycles.
6. Issue 260 writes with the timing counter held off frame start -> `drop_cnt` saturates at 255; no window starts until frame start is restored.
